xy_motion_arbiter: RTL and testbench

//  Owns the X/Y stepper drive pins and decides who moves the gantry: the four push-buttons or the

---
 rtl/xy_motion_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_xy_motion_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/xy_motion_arbiter.sv
// X/Y stepper drive arbiter: buttons or CPU own the gantry. Each axis runs its own
// step generator with direction setup time, fixed pulse width and edge-to-edge period.

module xy_axis #(
  parameter int unsigned DIR_SETUP_CYC = 100,
  parameter int unsigned PULSE_CYC     = 200
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] tgt_per_i,
  input  logic        tgt_dir_i,
  output logic        step_o,
  output logic        dir_o
);
  localparam logic [31:0] SETUP_LAST = (DIR_SETUP_CYC == 0) ? 32'd0 : 32'(DIR_SETUP_CYC - 1);
  localparam logic [31:0] PULSE_LAST = (PULSE_CYC == 0) ? 32'd0 : 32'(PULSE_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, GAP} state_e;

  state_e      state_q;
  logic [31:0] cnt_q;
  logic [31:0] per_q;
  logic        step_q;
  logic        dir_q;
  logic        gap_done;

  // cnt_q counts edges since the rising edge, so the GAP exit lands exactly on the period
  assign gap_done = (cnt_q >= per_q - 32'd1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      per_q   <= '0;
      step_q  <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_q + 32'd1;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (tgt_per_i != '0) begin
            state_q <= SETUP;
            dir_q   <= tgt_dir_i;
            per_q   <= tgt_per_i;
          end
        end
        SETUP: begin
          if (cnt_q >= SETUP_LAST) begin
            state_q <= PULSE;
            step_q  <= 1'b1;
            cnt_q   <= '0;
            // a stop seen during setup still emits one pulse on the last known period
            if (tgt_per_i != '0) per_q <= tgt_per_i;
          end
        end
        PULSE: begin
          if (cnt_q >= PULSE_LAST) begin
            state_q <= GAP;
            step_q  <= 1'b0;
          end
        end
        GAP: begin
          if (gap_done) begin
            cnt_q <= '0;
            if (tgt_per_i == '0) begin
              state_q <= IDLE;
            end else if (tgt_dir_i != dir_q) begin
              state_q <= SETUP;
              dir_q   <= tgt_dir_i;
            end else begin
              state_q <= PULSE;
              step_q  <= 1'b1;
              per_q   <= tgt_per_i;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign step_o = step_q;
  assign dir_o  = dir_q;
endmodule

module xy_motion_arbiter #(
  parameter int unsigned DIR_SETUP_CYC = 100,
  parameter int unsigned PULSE_CYC     = 200,
  parameter int unsigned MIN_PERIOD    = 1000,
  parameter int unsigned BTN_PERIOD    = 100000,
  parameter int unsigned CPU_TIMEOUT   = 50000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        cpu_en,
  input  logic        cpu_cmd_valid,
  input  logic [31:0] cpu_x_period,
  input  logic        cpu_x_dir,
  input  logic [31:0] cpu_y_period,
  input  logic        cpu_y_dir,
  output logic        x_step,
  output logic        x_dir,
  output logic        y_step,
  output logic        y_dir,
  output logic [1:0]  owner,
  output logic        cpu_timeout
);
  localparam int unsigned NUM_AXES = 2;  // index 0 = X, 1 = Y
  localparam logic [31:0] MIN_P = 32'(MIN_PERIOD);
  localparam logic [31:0] BTN_P = 32'(BTN_PERIOD);
  localparam logic [31:0] TO_P  = 32'(CPU_TIMEOUT);

  typedef enum logic [1:0] {OWN_NONE = 2'b00, OWN_BTN = 2'b01, OWN_CPU = 2'b10} owner_e;

  function automatic logic [31:0] clamp_per(input logic [31:0] p);
    return (p != '0 && p < MIN_P) ? MIN_P : p;
  endfunction

  logic                               any_btn;
  owner_e                             owner_q, owner_d;
  logic [NUM_AXES-1:0][31:0]          tgt_per_q, tgt_per_d;
  logic [NUM_AXES-1:0]                tgt_dir_q, tgt_dir_d;
  logic [NUM_AXES-1:0][31:0]          lat_per_q, lat_per_d;
  logic [NUM_AXES-1:0]                lat_dir_q, lat_dir_d;
  logic                               armed_q, armed_d;
  logic [31:0]                        wd_q, wd_d;
  logic                               to_q, to_d;
  logic [NUM_AXES-1:0]                step_w, dir_w;

  always_comb begin
    any_btn   = btn_up | btn_down | btn_left | btn_right;
    owner_d   = OWN_NONE;
    tgt_per_d = '0;
    tgt_dir_d = '0;
    if (any_btn) begin
      owner_d = OWN_BTN;
      if (btn_left ^ btn_right) begin
        tgt_per_d[0] = BTN_P;
        tgt_dir_d[0] = btn_left;
      end
      if (btn_up ^ btn_down) begin
        tgt_per_d[1] = BTN_P;
        tgt_dir_d[1] = btn_up;
      end
    end else if (cpu_en && !to_q && armed_q) begin
      owner_d   = OWN_CPU;
      tgt_per_d = lat_per_q;
      tgt_dir_d = lat_dir_q;
    end

    // button activity disarms the CPU so a stale command cannot resume after release
    armed_d = any_btn ? 1'b0 : (cpu_cmd_valid ? 1'b1 : armed_q);

    lat_per_d = lat_per_q;
    lat_dir_d = lat_dir_q;
    if (cpu_cmd_valid) begin
      lat_per_d[0] = clamp_per(cpu_x_period);
      lat_per_d[1] = clamp_per(cpu_y_period);
      lat_dir_d[0] = cpu_x_dir;
      lat_dir_d[1] = cpu_y_dir;
    end

    if (cpu_cmd_valid || !cpu_en) wd_d = '0;
    else if (wd_q >= TO_P)        wd_d = wd_q;
    else                          wd_d = wd_q + 32'd1;
    to_d = cpu_cmd_valid ? 1'b0 : (to_q | (wd_d >= TO_P));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      owner_q   <= OWN_NONE;
      tgt_per_q <= '0;
      tgt_dir_q <= '0;
      lat_per_q <= '0;
      lat_dir_q <= '0;
      armed_q   <= 1'b0;
      wd_q      <= '0;
      to_q      <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      tgt_per_q <= tgt_per_d;
      tgt_dir_q <= tgt_dir_d;
      lat_per_q <= lat_per_d;
      lat_dir_q <= lat_dir_d;
      armed_q   <= armed_d;
      wd_q      <= wd_d;
      to_q      <= to_d;
    end
  end

  for (genvar a = 0; a < NUM_AXES; a++) begin : g_axis
    xy_axis #(
      .DIR_SETUP_CYC(DIR_SETUP_CYC),
      .PULSE_CYC    (PULSE_CYC)
    ) u_axis (
      .clock    (clock),
      .reset    (reset),
      .tgt_per_i(tgt_per_q[a]),
      .tgt_dir_i(tgt_dir_q[a]),
      .step_o   (step_w[a]),
      .dir_o    (dir_w[a])
    );
  end

  assign x_step      = step_w[0];
  assign x_dir       = dir_w[0];
  assign y_step      = step_w[1];
  assign y_dir       = dir_w[1];
  assign owner       = owner_q;
  assign cpu_timeout = to_q;
endmodule

// File: tb/tb_xy_motion_arbiter.sv
// Directed bench for xy_motion_arbiter: timestamp-based reference model checked every
// cycle, plus literal timing expectations for each scenario.

module tb_xy_motion_arbiter;
  localparam int D    = 4;
  localparam int P    = 3;
  localparam int MINP = 10;
  localparam int BTNP = 20;
  localparam int TO   = 100;

  logic        clock, reset;
  logic        btn_up, btn_down, btn_left, btn_right;
  logic        cpu_en, cpu_cmd_valid;
  logic [31:0] cpu_x_period, cpu_y_period;
  logic        cpu_x_dir, cpu_y_dir;
  logic        x_step, x_dir, y_step, y_dir, cpu_timeout;
  logic [1:0]  owner;

  xy_motion_arbiter #(
    .DIR_SETUP_CYC(D), .PULSE_CYC(P), .MIN_PERIOD(MINP), .BTN_PERIOD(BTNP), .CPU_TIMEOUT(TO)
  ) dut (
    .clock(clock), .reset(reset),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .cpu_en(cpu_en), .cpu_cmd_valid(cpu_cmd_valid),
    .cpu_x_period(cpu_x_period), .cpu_x_dir(cpu_x_dir),
    .cpu_y_period(cpu_y_period), .cpu_y_dir(cpu_y_dir),
    .x_step(x_step), .x_dir(x_dir), .y_step(y_step), .y_dir(y_dir),
    .owner(owner), .cpu_timeout(cpu_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;  // index of the most recent rising clock edge

  // ---------------- reference model (updated at each rising edge) ----------------
  bit       m_armed, m_to;
  int       m_wd;
  bit [1:0] m_owner;
  int       m_lat_p[2], m_tp[2];
  bit       m_lat_d[2], m_td[2];
  bit       m_run[2];      // a pulse/gap cycle is in progress
  int       m_rise_at[2];  // scheduled first rise after direction setup, -1 if none
  int       m_last[2];     // edge of the most recent rising edge
  int       m_per[2];
  bit       m_dir[2], m_step[2];

  initial begin
    m_armed = 0; m_to = 0; m_wd = 0; m_owner = 0;
    for (int a = 0; a < 2; a++) begin
      m_lat_p[a] = 0; m_lat_d[a] = 0; m_tp[a] = 0; m_td[a] = 0;
      m_run[a] = 0; m_rise_at[a] = -1; m_last[a] = 0; m_per[a] = 0;
      m_dir[a] = 0; m_step[a] = 0;
    end
    forever begin
      @(posedge clock);
      cyc++;
      if (reset) begin
        m_armed = 0; m_to = 0; m_wd = 0; m_owner = 0;
        for (int a = 0; a < 2; a++) begin
          m_lat_p[a] = 0; m_lat_d[a] = 0; m_tp[a] = 0; m_td[a] = 0;
          m_run[a] = 0; m_rise_at[a] = -1; m_dir[a] = 0; m_step[a] = 0;
        end
      end else begin
        bit any;
        int gap;
        for (int a = 0; a < 2; a++) begin
          if (m_run[a]) begin
            gap = (m_per[a] > P) ? m_per[a] : P + 1;
            if (cyc == m_last[a] + gap) begin
              if (m_tp[a] == 0) m_run[a] = 0;
              else if (m_td[a] != m_dir[a]) begin
                m_dir[a] = m_td[a]; m_run[a] = 0; m_rise_at[a] = cyc + D;
              end else begin
                m_last[a] = cyc; m_per[a] = m_tp[a];
              end
            end
          end else if (m_rise_at[a] >= 0) begin
            if (cyc == m_rise_at[a]) begin
              m_last[a] = cyc; m_run[a] = 1; m_rise_at[a] = -1;
              if (m_tp[a] != 0) m_per[a] = m_tp[a];
            end
          end else if (m_tp[a] != 0) begin
            m_dir[a] = m_td[a]; m_per[a] = m_tp[a]; m_rise_at[a] = cyc + D;
          end
          m_step[a] = m_run[a] && (cyc - m_last[a] < P);
        end
        any = btn_up | btn_down | btn_left | btn_right;
        m_owner = 0;
        for (int a = 0; a < 2; a++) begin m_tp[a] = 0; m_td[a] = 0; end
        if (any) begin
          m_owner = 1;
          if (btn_left != btn_right) begin m_tp[0] = BTNP; m_td[0] = btn_left; end
          if (btn_up != btn_down)    begin m_tp[1] = BTNP; m_td[1] = btn_up;   end
        end else if (cpu_en && !m_to && m_armed) begin
          m_owner = 2;
          for (int a = 0; a < 2; a++) begin m_tp[a] = m_lat_p[a]; m_td[a] = m_lat_d[a]; end
        end
        if (any) m_armed = 0; else if (cpu_cmd_valid) m_armed = 1;
        if (cpu_cmd_valid) begin
          m_lat_p[0] = (cpu_x_period != 0 && cpu_x_period < MINP) ? MINP : int'(cpu_x_period);
          m_lat_p[1] = (cpu_y_period != 0 && cpu_y_period < MINP) ? MINP : int'(cpu_y_period);
          m_lat_d[0] = cpu_x_dir; m_lat_d[1] = cpu_y_dir;
        end
        if (cpu_cmd_valid || !cpu_en) m_wd = 0;
        else if (m_wd < TO) m_wd++;
        m_to = cpu_cmd_valid ? 1'b0 : (m_to || m_wd >= TO);
      end
    end
  end

  // ---------------- per-cycle compare and event monitor ----------------
  logic [6:0] act_v, exp_v;
  int rise_x[$], fall_x[$], rise_y[$], dirchg_x[$], to_rise[$];
  logic p_xs = 0, p_ys = 0, p_xd = 0, p_to = 0;

  always @(negedge clock) begin
    act_v = {x_step, x_dir, y_step, y_dir, owner, cpu_timeout};
    exp_v = {m_step[0], m_dir[0], m_step[1], m_dir[1], m_owner, m_to};
    if (cyc >= 1) begin
      n_total++;
      if (act_v === exp_v) n_pass++;
      else $display("FAIL model cyc=%0d got {xs,xd,ys,yd,own,to}=%b expected %b", cyc, act_v, exp_v);
    end
    if (x_step && !p_xs) rise_x.push_back(cyc);
    if (!x_step && p_xs) fall_x.push_back(cyc);
    if (y_step && !p_ys) rise_y.push_back(cyc);
    if (x_dir != p_xd)   dirchg_x.push_back(cyc);
    if (cpu_timeout && !p_to) to_rise.push_back(cyc);
    p_xs = x_step; p_ys = y_step; p_xd = x_dir; p_to = cpu_timeout;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic clr();
    rise_x.delete(); fall_x.delete(); rise_y.delete(); dirchg_x.delete(); to_rise.delete();
  endtask

  task automatic wait_xrise(input string nm, input int budget, output int r);
    int n0;
    bit got;
    n0 = rise_x.size(); got = 0; r = -1;
    for (int i = 0; i < budget && !got; i++) begin
      tick(1);
      if (rise_x.size() > n0) begin got = 1; r = rise_x[rise_x.size()-1]; end
    end
    if (!got) begin
      n_total++;
      $display("FAIL %s: no x_step rise within %0d cycles", nm, budget);
    end
  endtask

  task automatic strobe(input int xp, input bit xd, input int yp, input bit yd, output int s);
    cpu_x_period = 32'(xp); cpu_x_dir = xd; cpu_y_period = 32'(yp); cpu_y_dir = yd;
    cpu_cmd_valid = 1; s = cyc + 1;
    tick(1);
    cpu_cmd_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int t0, s, r, r2;
    reset = 1; btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    cpu_en = 0; cpu_cmd_valid = 0; cpu_x_period = 0; cpu_x_dir = 0; cpu_y_period = 0; cpu_y_dir = 0;
    tick(3);
    chk("reset_outputs", {x_step, x_dir, y_step, y_dir, owner, cpu_timeout}, 0);
    reset = 0;
    tick(2);

    // 1: btn_right -> +X at button period
    clr(); btn_right = 1; t0 = cyc + 1;
    tick(1);
    chk("s1_owner_btn", owner, 1);
    tick(59);
    chk("s1_rise_count", rise_x.size(), 3);
    if (rise_x.size() >= 2 && fall_x.size() >= 1) begin
      chk("s1_first_rise_lat", rise_x[0] - t0, 5);
      chk("s1_pulse_width", fall_x[0] - rise_x[0], 3);
      chk("s1_spacing", rise_x[1] - rise_x[0], 20);
    end
    chk("s1_y_idle", rise_y.size(), 0);
    btn_right = 0;
    tick(40);

    // 1b: btn_up -> +Y
    clr(); btn_up = 1; t0 = cyc + 1;
    tick(30);
    if (rise_y.size() >= 1) chk("s1b_y_rise_lat", rise_y[0] - t0, 5);
    chk("s1b_y_dir", y_dir, 1);
    btn_up = 0;
    tick(30);

    // 2: CPU period below minimum clamps up
    clr(); cpu_en = 1;
    strobe(5, 1, 0, 0, s);
    tick(44);
    chk("s2_rise_count", rise_x.size(), 4);
    if (rise_x.size() >= 2) begin
      chk("s2_first_rise_lat", rise_x[0] - s, 6);
      chk("s2_spacing_clamped", rise_x[1] - rise_x[0], 10);
    end
    chk("s2_x_dir", x_dir, 1);
    chk("s2_owner_cpu", owner, 2);

    // 3: buttons take over, axis winds down, CPU stays disarmed after release
    strobe(30, 0, 0, 0, s);
    tick(30);
    btn_left = 1; btn_right = 1;
    tick(1);
    chk("s3_owner_btn", owner, 1);
    tick(39);
    clr(); btn_left = 0; btn_right = 0;
    tick(20);
    chk("s3_no_motion_after_release", rise_x.size(), 0);
    chk("s3_owner_none", owner, 0);

    // 4: watchdog expiry then recovery by strobe
    clr();
    strobe(10, 0, 0, 0, s);
    tick(149);
    chk("s4_timeout_seen", to_rise.size(), 1);
    if (to_rise.size() >= 1) chk("s4_timeout_edge", to_rise[0] - s, 100);
    chk("s4_owner_none", owner, 0);
    chk("s4_timeout_flag", cpu_timeout, 1);
    strobe(30, 0, 0, 0, s);
    chk("s4_timeout_cleared", cpu_timeout, 0);
    wait_xrise("s4_restart", 20, r);
    if (r >= 0) chk("s4_restart_lat", r - s, 6);

    // 5: direction flip mid-GAP
    clr();
    tick(9);
    strobe(30, 1, 0, 0, s);
    tick(30);
    if (r >= 0) begin
      chk("s5_rise_count", rise_x.size(), 1);
      if (rise_x.size() >= 1) chk("s5_rise_after_flip", rise_x[0] - r, 34);
      chk("s5_dirchg_count", dirchg_x.size(), 1);
      if (dirchg_x.size() >= 1) chk("s5_dir_change_edge", dirchg_x[0] - r, 30);
    end

    // 6: reset mid-PULSE
    wait_xrise("s6_wait_pulse", 40, r2);
    reset = 1; btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; cpu_en = 0;
    tick(1);
    chk("s6_reset_outputs", {x_step, x_dir, y_step, y_dir, owner, cpu_timeout}, 0);
    tick(2);
    clr(); reset = 0;
    tick(30);
    chk("s6_idle_outputs", {x_step, x_dir, y_step, y_dir, owner, cpu_timeout}, 0);
    chk("s6_idle_rises", rise_x.size() + rise_y.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
